mgmt_rx_frame_fifo: RTL and testbench



---
 rtl/mgmt_fifo_pkg.sv | 18 +
 rtl/rx_frame_len_fifo.sv | 53 +++++
 rtl/mgmt_rx_frame_fifo.sv | 170 +++++++++++++++++
 tb/tb_mgmt_rx_frame_fifo.sv | 319 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mgmt_fifo_pkg.sv
// rtl/mgmt_fifo_pkg.sv - shared types and constants for the management receive frame FIFO
package mgmt_fifo_pkg;

  // Frame lengths are carried as 11-bit byte counts (covers 1500-byte frames plus one word of overshoot)
  localparam int HDR_LEN_W = 11;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCEPT   = 2'd1,
    DROPPING = 2'd2
  } wr_state_e;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/rx_frame_len_fifo.sv
// rtl/rx_frame_len_fifo.sv - single-clock first-word-fall-through FIFO of committed frame lengths
module rx_frame_len_fifo
  import mgmt_fifo_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int WIDTH = HDR_LEN_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = ((wr_ptr - rd_ptr) == (AW+1)'(DEPTH));
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // Oldest entry is visible without a read strobe; forced to zero while empty so reset shows zero
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Entry storage, written on push only
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  // Pointer maintenance with synchronous flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/mgmt_rx_frame_fifo.sv
// rtl/mgmt_rx_frame_fifo.sv - receive frame FIFO with commit/rollback and per-frame length header
module mgmt_rx_frame_fifo
  import mgmt_fifo_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int DEPTH      = 4096,
  parameter int HDR_DEPTH  = 32,
  parameter int MAX_FRAME  = 1500
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          link_up,
  input  logic                          rx_start,
  input  logic                          rx_data_valid,
  input  logic                          rx_commit,
  input  logic                          rx_drop,
  input  logic [8*DATA_BYTES-1:0]       rx_data,
  input  logic [$clog2(DATA_BYTES):0]   rx_bytes_valid,
  output logic                          hdr_valid,
  output logic [HDR_LEN_W-1:0]          hdr_len,
  input  logic                          rd_en,
  output logic [8*DATA_BYTES-1:0]       rd_data,
  input  logic                          rd_frame_done,
  output logic [31:0]                   frame_count,
  output logic [31:0]                   drop_count
);

  localparam int DW        = 8 * DATA_BYTES;
  localparam int AW        = $clog2(DEPTH);
  localparam int PW        = AW + 1;
  localparam int LW        = HDR_LEN_W;
  localparam int BSH       = $clog2(DATA_BYTES);
  localparam int MAX_WORDS = (MAX_FRAME + DATA_BYTES - 1) / DATA_BYTES;

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] ram_q;
  logic          rd_seen;

  logic [PW-1:0] wr_ptr, commit_ptr, rd_ptr, frame_start;
  logic [PW-1:0] free_words, frame_words;
  wr_state_e     state;
  logic [LW-1:0] framelen, final_len;
  logic [LW:0]   len_sum, hdr_len_rnd;

  logic too_long, start_ok, abort;
  logic wr_fire, commit_fire, rd_fire;
  logic hdr_push, hdr_pop, hdr_full, hdr_empty;

  // Space is only returned when a frame is released, so free is measured from frame_start
  assign free_words  = PW'(DEPTH) - (wr_ptr - frame_start);
  assign len_sum     = {1'b0, framelen} + (LW+1)'(rx_bytes_valid);
  assign too_long    = len_sum > (LW+1)'(MAX_FRAME);
  assign start_ok    = (free_words >= PW'(MAX_WORDS)) && !hdr_full;
  assign abort       = (state == ACCEPT) &&
                       (rx_drop || (rx_data_valid && ((free_words == '0) || too_long)));
  assign wr_fire     = link_up && (state == ACCEPT) && rx_data_valid && !abort;
  assign commit_fire = link_up && (state == ACCEPT) && rx_commit && !abort;
  // A word arriving with the commit belongs to the frame
  assign final_len   = rx_data_valid ? len_sum[LW-1:0] : framelen;
  assign hdr_push    = commit_fire && (final_len != '0);

  assign hdr_valid   = !hdr_empty;
  assign hdr_pop     = link_up && rd_frame_done && hdr_valid;
  assign rd_fire     = link_up && rd_en && (rd_ptr != commit_ptr);
  assign hdr_len_rnd = {1'b0, hdr_len} + (LW+1)'(DATA_BYTES - 1);
  assign frame_words = PW'(hdr_len_rnd >> BSH);
  // RAM output register has no reset; the gate gives rd_data an asynchronous zero after reset
  assign rd_data     = rd_seen ? ram_q : '0;

  rx_frame_len_fifo #(
    .DEPTH (HDR_DEPTH),
    .WIDTH (LW)
  ) u_len_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (!link_up),
    .push      (hdr_push),
    .push_data (final_len),
    .pop       (hdr_pop),
    .pop_data  (hdr_len),
    .full      (hdr_full),
    .empty     (hdr_empty)
  );

  // Simple dual-port data RAM: write port from receive side, registered read port
  always_ff @(posedge clk) begin
    if (wr_fire) mem[wr_ptr[AW-1:0]] <= rx_data;
    if (rd_fire) ram_q <= mem[rd_ptr[AW-1:0]];
  end

  // Read pointer and frame release; a release in the same cycle as a read overrides the increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      frame_start <= '0;
      rd_seen     <= 1'b0;
    end else if (!link_up) begin
      rd_ptr      <= '0;
      frame_start <= '0;
    end else begin
      if (rd_fire) begin
        rd_ptr  <= rd_ptr + PW'(1);
        rd_seen <= 1'b1;
      end
      if (hdr_pop) begin
        rd_ptr      <= frame_start + frame_words;
        frame_start <= frame_start + frame_words;
      end
    end
  end

  // Write FSM: accept, roll back or discard incoming frames and keep the frame/drop counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wr_ptr      <= '0;
      commit_ptr  <= '0;
      framelen    <= '0;
      frame_count <= '0;
      drop_count  <= '0;
    end else if (!link_up) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      framelen   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_start) begin
            if (start_ok) begin
              state    <= ACCEPT;
              framelen <= '0;
              wr_ptr   <= commit_ptr;
            end else begin
              state      <= DROPPING;
              drop_count <= sat_inc(drop_count);
            end
          end
        end
        ACCEPT: begin
          if (abort) begin
            wr_ptr     <= commit_ptr;
            state      <= DROPPING;
            drop_count <= sat_inc(drop_count);
          end else begin
            if (rx_data_valid) begin
              wr_ptr   <= wr_ptr + PW'(1);
              framelen <= len_sum[LW-1:0];
            end
            if (rx_commit) begin
              state <= IDLE;
              if (final_len != '0) begin
                commit_ptr  <= rx_data_valid ? wr_ptr + PW'(1) : wr_ptr;
                frame_count <= sat_inc(frame_count);
              end else begin
                wr_ptr     <= commit_ptr;
                drop_count <= sat_inc(drop_count);
              end
            end
          end
        end
        DROPPING: begin
          if (rx_commit || rx_drop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mgmt_rx_frame_fifo.sv
// tb/tb_mgmt_rx_frame_fifo.sv - self-checking bench for mgmt_rx_frame_fifo
module tb_mgmt_rx_frame_fifo;

  localparam int DB        = 4;
  localparam int DEPTH     = 512;
  localparam int HDR_DEPTH = 32;
  localparam int MAX_FRAME = 1500;
  localparam int MAX_WORDS = (MAX_FRAME + DB - 1) / DB;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        link_up = 1'b1;
  logic        rx_start = 1'b0;
  logic        rx_data_valid = 1'b0;
  logic        rx_commit = 1'b0;
  logic        rx_drop = 1'b0;
  logic [31:0] rx_data = '0;
  logic [2:0]  rx_bytes_valid = '0;
  logic        hdr_valid;
  logic [10:0] hdr_len;
  logic        rd_en = 1'b0;
  logic [31:0] rd_data;
  logic        rd_frame_done = 1'b0;
  logic [31:0] frame_count;
  logic [31:0] drop_count;

  always #5 clk = ~clk;

  mgmt_rx_frame_fifo #(
    .DATA_BYTES (DB),
    .DEPTH      (DEPTH),
    .HDR_DEPTH  (HDR_DEPTH),
    .MAX_FRAME  (MAX_FRAME)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .link_up        (link_up),
    .rx_start       (rx_start),
    .rx_data_valid  (rx_data_valid),
    .rx_commit      (rx_commit),
    .rx_drop        (rx_drop),
    .rx_data        (rx_data),
    .rx_bytes_valid (rx_bytes_valid),
    .hdr_valid      (hdr_valid),
    .hdr_len        (hdr_len),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_frame_done  (rd_frame_done),
    .frame_count    (frame_count),
    .drop_count     (drop_count)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  // Model: committed-but-unreleased words, their frame lengths, and the frame being received
  logic [31:0] wq[$];
  int          fl[$];
  logic [31:0] m_cur[$];
  int          roff;
  int          m_len;
  int          m_st;      // 0 waiting for start, 1 collecting, 2 discarding
  logic [31:0] m_fc, m_dc, m_rd;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    wq.delete(); fl.delete(); m_cur.delete();
    roff = 0; m_len = 0; m_st = 0;
    m_fc = '0; m_dc = '0; m_rd = '0;
  endfunction

  function automatic void bump_drop();
    if (m_dc != 32'hFFFF_FFFF) m_dc++;
  endfunction

  task automatic model_edge(input bit st, input bit dv, input logic [31:0] d, input int bv,
                            input bit cm, input bit dr, input bit rd, input bit dn, input bit lk);
    int  free_pre;
    bit  hfull_pre;
    bit  ab;
    int  n;
    if (!lk) begin
      wq.delete(); fl.delete(); m_cur.delete();
      roff = 0; m_st = 0; m_len = 0;
      return;
    end
    free_pre  = DEPTH - wq.size() - m_cur.size();
    hfull_pre = (fl.size() >= HDR_DEPTH);
    if (rd && roff < wq.size()) begin
      m_rd = wq[roff];
      roff++;
    end
    if (dn && fl.size() != 0) begin
      n = (fl[0] + DB - 1) / DB;
      repeat (n) void'(wq.pop_front());
      void'(fl.pop_front());
      roff = 0;
    end
    case (m_st)
      0: if (st) begin
        if (free_pre < MAX_WORDS || hfull_pre) begin
          m_st = 2; bump_drop();
        end else begin
          m_st = 1; m_len = 0; m_cur.delete();
        end
      end
      1: begin
        ab = dr || (dv && (free_pre == 0 || m_len + bv > MAX_FRAME));
        if (ab) begin
          m_cur.delete(); m_st = 2; bump_drop();
        end else begin
          if (dv) begin
            m_cur.push_back(d); m_len += bv;
          end
          if (cm) begin
            if (m_len == 0) bump_drop();
            else begin
              fl.push_back(m_len);
              foreach (m_cur[i]) wq.push_back(m_cur[i]);
              if (m_fc != 32'hFFFF_FFFF) m_fc++;
            end
            m_cur.delete(); m_st = 0;
          end
        end
      end
      default: if (cm || dr) m_st = 0;
    endcase
  endtask

  task automatic cyc(input bit st, input bit dv, input logic [31:0] d, input int bv,
                     input bit cm, input bit dr, input bit rd, input bit dn, input bit lk);
    @(negedge clk);
    rx_start = st; rx_data_valid = dv; rx_data = d; rx_bytes_valid = 3'(bv);
    rx_commit = cm; rx_drop = dr; rd_en = rd; rd_frame_done = dn; link_up = lk;
    @(posedge clk);
    model_edge(st, dv, d, bv, cm, dr, rd, dn, lk);
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0, '0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic send_frame(input int len, input logic [31:0] base, input bit cm_last);
    int nw;
    int bv;
    nw = (len + DB - 1) / DB;
    cyc(1, 0, '0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < nw; i++) begin
      bv = (i == nw - 1 && (len % DB) != 0) ? (len % DB) : DB;
      cyc(0, 1, base + 32'(i), bv, cm_last && (i == nw - 1), 0, 0, 0, 1);
    end
    if (!cm_last || nw == 0) cyc(0, 0, '0, 0, 1, 0, 0, 0, 1);
  endtask

  task automatic rd_words(input int n);
    repeat (n) cyc(0, 0, '0, 0, 0, 0, 1, 0, 1);
  endtask

  task automatic release_frame();
    cyc(0, 0, '0, 0, 0, 0, 0, 1, 1);
  endtask

  // Continuous comparison against the model on every falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("hdr_valid", 32'(hdr_valid), 32'(fl.size() != 0));
      if (fl.size() != 0) chk("hdr_len", 32'(hdr_len), 32'(fl[0]));
      chk("frame_count", frame_count, m_fc);
      chk("drop_count", drop_count, m_dc);
      chk("rd_data", rd_data, m_rd);
    end
  end

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset hdr_valid", 32'(hdr_valid), 32'd0);
    chk("reset rd_data", rd_data, 32'd0);
    chk("reset frame_count", frame_count, 32'd0);
    chk("reset drop_count", drop_count, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1;
    idle(2);

    // 64-byte frame, commit on its own cycle, read all 16 words
    send_frame(64, 32'hA000_0000, 0);
    #1;
    chk("t1 hdr_len", 32'(hdr_len), 32'd64);
    chk("t1 frame_count", frame_count, 32'd1);
    rd_words(16);
    #1;
    chk("t1 last word", rd_data, 32'hA000_000F);
    rd_words(1);
    #1;
    chk("t1 read past commit held", rd_data, 32'hA000_000F);
    release_frame();
    idle(1);

    // 1501-byte frame rolls back on the overflowing word
    send_frame(1501, 32'h1000_0000, 0);
    #1;
    chk("t2 drop_count", drop_count, 32'd1);
    chk("t2 no header", 32'(hdr_valid), 32'd0);
    chk("t2 frame_count", frame_count, 32'd1);

    // 800-byte frame committed with its last word, then a new frame finds only 312 words free
    send_frame(800, 32'h8000_0000, 1);
    #1;
    chk("t3 hdr_len", 32'(hdr_len), 32'd800);
    chk("t3 frame_count", frame_count, 32'd2);
    send_frame(64, 32'h9000_0000, 1);
    #1;
    chk("t3 drop_count", drop_count, 32'd2);
    chk("t3 frame_count kept", frame_count, 32'd2);
    release_frame();
    #1;
    chk("t3 released", 32'(hdr_valid), 32'd0);

    // Early release after 3 of 16 words, then next frame reads from its own start
    send_frame(64, 32'hB000_0000, 0);
    send_frame(64, 32'hC000_0000, 1);
    rd_words(3);
    release_frame();
    #1;
    chk("t4 next hdr_len", 32'(hdr_len), 32'd64);
    rd_words(1);
    #1;
    chk("t4 first word of next", rd_data, 32'hC000_0000);
    rd_words(2);
    cyc(0, 0, '0, 0, 0, 0, 1, 1, 1);
    #1;
    chk("t4 read with release", rd_data, 32'hC000_0003);
    chk("t4 header popped", 32'(hdr_valid), 32'd0);
    rd_words(1);
    #1;
    chk("t4 empty read held", rd_data, 32'hC000_0003);

    // Zero-length commit counts as a drop
    send_frame(0, '0, 0);
    #1;
    chk("t5 zero len drop", drop_count, 32'd3);
    chk("t5 no header", 32'(hdr_valid), 32'd0);

    // Partial last word
    send_frame(10, 32'hD000_0000, 0);
    #1;
    chk("t6 hdr_len", 32'(hdr_len), 32'd10);
    rd_words(3);
    #1;
    chk("t6 last word", rd_data, 32'hD000_0002);
    release_frame();

    // Explicit rx_drop mid-frame, then a commit while discarding
    cyc(1, 0, '0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 32'hE000_0000 + 32'(i), DB, 0, 0, 0, 0, 1);
    cyc(0, 0, '0, 0, 0, 1, 0, 0, 1);
    cyc(0, 0, '0, 0, 1, 0, 0, 0, 1);
    #1;
    chk("t7 drop_count", drop_count, 32'd4);
    chk("t7 frame_count", frame_count, 32'd5);

    // Link drop with one committed frame pending and another in progress
    send_frame(64, 32'h2000_0000, 0);
    cyc(1, 0, '0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 32'h3000_0000 + 32'(i), DB, 0, 0, 0, 0, 1);
    cyc(0, 0, '0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t8 hdr_valid after flush", 32'(hdr_valid), 32'd0);
    chk("t8 frame_count kept", frame_count, 32'd6);
    chk("t8 drop_count kept", drop_count, 32'd4);
    idle(1);
    send_frame(64, 32'h4000_0000, 0);
    #1;
    chk("t8 new frame hdr_len", 32'(hdr_len), 32'd64);
    rd_words(1);
    #1;
    chk("t8 new frame first word", rd_data, 32'h4000_0000);
    rd_words(15);
    release_frame();

    // Asynchronous reset in the middle of a read
    send_frame(64, 32'h5000_0000, 0);
    rd_words(2);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t9 hdr_valid", 32'(hdr_valid), 32'd0);
    chk("t9 hdr_len", 32'(hdr_len), 32'd0);
    chk("t9 rd_data", rd_data, 32'd0);
    chk("t9 frame_count", frame_count, 32'd0);
    chk("t9 drop_count", drop_count, 32'd0);
    @(negedge clk);
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(1);
    send_frame(8, 32'h6000_0000, 1);
    rd_words(2);
    #1;
    chk("t9 after reset frame", rd_data, 32'h6000_0001);
    idle(2);

    chk_en = 0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
